// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus for apb_master.
// The master modport is the DUT's view; slave is the view of the system around it.
`timescale 1ns/1ps
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one command in IDLE, runs SETUP/ACCESS,
// and reports completion with a one-cycle rsp_valid pulse (slave error or timeout).
`timescale 1ns/1ps
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // ACCESS cycles seen so far with pready low; TIMEOUT is capped at 255.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_slverr  <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            state         <= SETUP;
            wait_cnt      <= '0;
            bus.cmd_ready <= 1'b0;
            bus.psel      <= 1'b1;
            bus.paddr     <= bus.cmd_addr;
            bus.pwrite    <= bus.cmd_write;
            bus.pwdata    <= bus.cmd_write ? bus.cmd_wdata : '0;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end
        ACCESS: begin
          if (!bus.pready) wait_cnt <= wait_cnt + 8'd1;
          // pready in the final allowed cycle still completes normally.
          if (bus.pready || wait_cnt == LAST_WAIT) begin
            state           <= IDLE;
            bus.cmd_ready   <= 1'b1;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_timeout <= !bus.pready;
            bus.rsp_slverr  <= !bus.pready || bus.pslverr;
            bus.rsp_rdata   <= (bus.pready && !bus.pslverr && !bus.pwrite) ? bus.prdata : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// Randomized + directed bench for apb_master against a transaction-timeline model.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int IDLE_P = 0, SETUP_P = 1, ACC_P = 2, RSP_P = 3;

  // w = ACCESS cycle (1-based) in which the slave raises pready; w > TO never does.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            w;
    logic          err;
    logic [DW-1:0] rdata;
  } cmd_t;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  int   vectors = 0, miscompares = 0, cyc = 0;
  cmd_t cq[$];
  cmd_t t;
  int   acc_log[$];
  bit   busy, started, rnd_en, drv_valid;
  int   d, ph, acc_n, last_rsp_cyc, pulses;
  logic e_ready, e_psel, e_pen, e_pwrite, e_rv, e_slverr, e_to;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rdata;

  function automatic int acc_len(int w);
    return (w <= TO) ? w : TO;
  endfunction

  function automatic cmd_t mk(logic wr, logic [AW-1:0] a, logic [DW-1:0] wd, int w,
                              logic err, logic [DW-1:0] rd);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.w = w; c.err = err; c.rdata = rd;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom_range(0, 1)), $urandom(), $urandom(), int'($urandom_range(1, TO + 1)),
              1'($urandom_range(0, 3) == 0), $urandom());
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy = 0; started = 0; ph = IDLE_P; d = 0;
    cq.delete(); acc_log.delete();
    e_ready = 0; e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0;
    e_rv = 0; e_rdata = '0; e_slverr = 0; e_to = 0;
  endtask

  // Drive command and slave inputs; slave responses follow the model's timeline.
  task automatic drive();
    if (rnd_en && cq.size() == 0 && $urandom_range(0, 2) == 0) cq.push_back(rand_cmd());
    drv_valid     = (cq.size() > 0);
    bus.cmd_valid = drv_valid;
    if (drv_valid) begin
      bus.cmd_write = cq[0].wr; bus.cmd_addr = cq[0].addr; bus.cmd_wdata = cq[0].wdata;
    end else begin
      bus.cmd_write = 1'($urandom_range(0, 1)); bus.cmd_addr = $urandom(); bus.cmd_wdata = $urandom();
    end
    if (ph == ACC_P && (d - 1) == t.w) begin
      bus.pready = 1'b1; bus.pslverr = t.err; bus.prdata = t.rdata;
    end else begin
      bus.pready  = (ph == ACC_P) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.pslverr = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom();
    end
  endtask

  // Outputs after an edge follow from the cycle distance d to the accept edge:
  // d=1 SETUP, d=2..1+len ACCESS, d=2+len completion pulse.
  task automatic advance();
    cyc++;
    if (busy) begin
      d++;
      if (d == 2 + acc_len(t.w)) begin
        ph       = RSP_P;
        busy     = 0;
        e_to     = (t.w > TO);
        e_slverr = e_to || t.err;
        e_rdata  = (!t.wr && !e_slverr) ? t.rdata : '0;
      end else ph = ACC_P;
    end else if (drv_valid && e_ready) begin
      t = cq.pop_front();
      busy = 1; d = 1; ph = SETUP_P;
      acc_n = cyc - 1;
      acc_log.push_back(acc_n);
      e_paddr = t.addr; e_pwrite = t.wr;
    end else ph = IDLE_P;
    started  = 1;
    e_psel   = (ph == SETUP_P || ph == ACC_P);
    e_pen    = (ph == ACC_P);
    e_pwdata = (e_psel && t.wr) ? t.wdata : '0;
    e_ready  = started && !e_psel;
    e_rv     = (ph == RSP_P);
  endtask

  task automatic compare();
    chk("cmd_ready",   64'(bus.cmd_ready),   64'(e_ready));
    chk("psel",        64'(bus.psel),        64'(e_psel));
    chk("penable",     64'(bus.penable),     64'(e_pen));
    chk("pwrite",      64'(bus.pwrite),      64'(e_pwrite));
    chk("paddr",       64'(bus.paddr),       64'(e_paddr));
    chk("pwdata",      64'(bus.pwdata),      64'(e_pwdata));
    chk("rsp_valid",   64'(bus.rsp_valid),   64'(e_rv));
    chk("rsp_rdata",   64'(bus.rsp_rdata),   64'(e_rdata));
    chk("rsp_slverr",  64'(bus.rsp_slverr),  64'(e_slverr));
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e_to));
    if (bus.rsp_valid) last_rsp_cyc = cyc;
  endtask

  task automatic step();
    @(negedge pclk);
    drive();
    @(posedge pclk); #1;
    advance();
    compare();
  endtask

  task automatic release_reset();
    @(negedge pclk);
    preset = 1'b0;
    drive();
    @(posedge pclk); #1;
    advance();
    compare();
  endtask

  // Issue one command and pin latency/response fields to hand-computed values.
  task automatic run_txn(string nm, cmd_t c, int lat, logic [DW-1:0] rd, logic se, logic tmo);
    bit seen;
    seen = 0;
    cq.push_back(c);
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = bus.rsp_valid;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s: no rsp_valid within 40 cycles", nm);
    end else begin
      chk({nm, "_lat"},     64'(last_rsp_cyc - acc_n), 64'(lat));
      chk({nm, "_rdata"},   64'(bus.rsp_rdata),        64'(rd));
      chk({nm, "_slverr"},  64'(bus.rsp_slverr),       64'(se));
      chk({nm, "_timeout"}, 64'(bus.rsp_timeout),      64'(tmo));
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    rnd_en = 0; last_rsp_cyc = 0; acc_n = 0; pulses = 0;
    t = mk(1'b0, '0, '0, 1, 1'b0, '0);
    model_reset();

    repeat (3) @(posedge pclk);
    #1 compare();
    release_reset();
    chk("ready_rise", 64'(bus.cmd_ready), 64'd1);

    run_txn("wr04",          mk(1'b1, 32'h4,  32'hDEADBEEF, 1, 1'b0, 32'h0),        3, 32'h0, 1'b0, 1'b0);
    run_txn("rd04_wait2",    mk(1'b0, 32'h4,  32'h0, 3, 1'b0, 32'hDEADBEEF),        5, 32'hDEADBEEF, 1'b0, 1'b0);
    run_txn("rd40_err",      mk(1'b0, 32'h40, 32'h0, 1, 1'b1, 32'h12345678),        3, 32'h0, 1'b1, 1'b0);
    run_txn("rd_timeout",    mk(1'b0, 32'h8,  32'h0, TO + 1, 1'b0, 32'h55AA55AA),   6, 32'h0, 1'b1, 1'b1);
    run_txn("rd_last_ready", mk(1'b0, 32'hC,  32'h0, TO, 1'b0, 32'hA5A5A5A5),       6, 32'hA5A5A5A5, 1'b0, 1'b0);
    run_txn("wr_err",        mk(1'b1, 32'h10, 32'hCAFEF00D, 2, 1'b1, 32'h0),        4, 32'h0, 1'b1, 1'b0);

    // Three writes with cmd_valid held high.
    acc_log.delete();
    for (int i = 0; i < 3; i++) cq.push_back(mk(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1, 1'b0, 32'h0));
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.rsp_valid) pulses++;
    end
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("b2b_accepts", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      chk("b2b_gap1", 64'(acc_log[1] - acc_log[0]), 64'd3);
      chk("b2b_gap2", 64'(acc_log[2] - acc_log[1]), 64'd3);
    end

    // Asynchronous reset in the middle of ACCESS.
    cq.push_back(mk(1'b0, 32'h20, 32'h0, TO + 1, 1'b0, 32'h0));
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_penable", 64'(bus.penable), 64'd1);
    #2 preset = 1'b1;
    #1;
    chk("arst_psel",      64'(bus.psel),      64'd0);
    chk("arst_penable",   64'(bus.penable),   64'd0);
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    model_reset();
    @(posedge pclk);
    #1 compare();
    release_reset();
    run_txn("post_rst_wr", mk(1'b1, 32'h80, 32'h0BADCAFE, 2, 1'b0, 32'h0), 4, 32'h0, 1'b0, 1'b0);

    rnd_en = 1;
    for (int i = 0; i < 1500; i++) step();
    rnd_en = 0;
    for (int i = 0; i < 40 && (busy || cq.size() > 0); i++) step();
    if (busy || cq.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: traffic still pending after 40 cycles");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
